// File: rtl/pong_pkg.sv
// Shared types and widths for the Pong game-flow controller.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int BCD_W   = 4;
    localparam int LIVES_W = 4;

endpackage

// File: rtl/rotary_decoder.sv
// Quadrature rotary-encoder front end: synchronizes rota/rotb and emits
// one-cycle paddle step pulses on each rising edge of the synchronized rota.
module rotary_decoder (
    input  logic Clock,
    input  logic Reset,
    input  logic rota,
    input  logic rotb,
    output logic paddle_up,
    output logic paddle_down
);

    logic a_p0, a_p1, a_p2;
    logic b_p0, b_p1;
    logic a_rise;

    assign a_rise = a_p1 & ~a_p2;

    // Two-flop synchronizers, a third rota flop for edge detection, registered step pulses
    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_p0        <= 1'b0;
            a_p1        <= 1'b0;
            a_p2        <= 1'b0;
            b_p0        <= 1'b0;
            b_p1        <= 1'b0;
            paddle_up   <= 1'b0;
            paddle_down <= 1'b0;
        end else begin
            a_p0        <= rota;
            a_p1        <= a_p0;
            a_p2        <= a_p1;
            b_p0        <= rotb;
            b_p1        <= b_p0;
            paddle_up   <= a_rise & ~b_p1;
            paddle_down <= a_rise &  b_p1;
        end
    end

endmodule

// File: rtl/pong_game_sequencer.sv
// Pong game-flow controller: frame tick from vsync, paddle steps from the
// encoder, and the idle/serve/play/over sequence with BCD score and lives.
module pong_game_sequencer
    import pong_pkg::*;
#(
    parameter int SERVE_FRAMES = 60,
    parameter int LIVES        = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               rota,
    input  logic               rotb,
    input  logic               vsync,
    input  logic               ball_hit,
    input  logic               ball_miss,
    output logic               frame_tick,
    output logic               paddle_up,
    output logic               paddle_down,
    output logic               ball_reset,
    output logic               ball_enable,
    output logic [2*BCD_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over
);

    localparam logic [7:0]         SERVE_N    = 8'(SERVE_FRAMES);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    // Two-digit BCD increment that sticks at 99
    function automatic logic [2*BCD_W-1:0] bcd_sat_inc(input logic [2*BCD_W-1:0] v);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        tens = v[2*BCD_W-1:BCD_W];
        ones = v[BCD_W-1:0];
        if (v == 8'h99)
            return v;
        else if (ones == BCD_W'(9))
            return {tens + BCD_W'(1), BCD_W'(0)};
        else
            return {tens, ones + BCD_W'(1)};
    endfunction

    logic v_p0, v_p1, v_p2;
    logic paddle;

    state_t             state, state_nxt;
    logic [7:0]         cnt, cnt_nxt;
    logic [2*BCD_W-1:0] score_nxt;
    logic [LIVES_W-1:0] lives_nxt;
    logic [LIVES_W-1:0] lives_dec;

    rotary_decoder u_rotary_decoder (
        .Clock       (Clock),
        .Reset       (Reset),
        .rota        (rota),
        .rotb        (rotb),
        .paddle_up   (paddle_up),
        .paddle_down (paddle_down)
    );

    assign paddle    = paddle_up | paddle_down;
    assign lives_dec = lives - LIVES_W'(1);

    // vsync synchronizer (idles high) and falling-edge frame tick
    always_ff @(posedge Clock) begin
        if (Reset) begin
            v_p0       <= 1'b1;
            v_p1       <= 1'b1;
            v_p2       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            v_p0       <= vsync;
            v_p1       <= v_p0;
            v_p2       <= v_p1;
            frame_tick <= ~v_p1 & v_p2;
        end
    end

    // Next-state, frame counter, score and lives decisions
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        score_nxt = score;
        lives_nxt = lives;
        case (state)
            ST_IDLE: begin
                if (paddle) begin
                    score_nxt = '0;
                    lives_nxt = LIVES_INIT;
                    cnt_nxt   = '0;
                    state_nxt = ST_SERVE;
                end
            end
            ST_SERVE: begin
                // Paddle pulses are deliberately ignored here, even on the completing tick
                if (frame_tick) begin
                    if (cnt + 8'd1 == SERVE_N) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_PLAY;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                // A miss outranks a simultaneous hit
                if (ball_miss) begin
                    lives_nxt = lives_dec;
                    cnt_nxt   = '0;
                    state_nxt = (lives_dec == '0) ? ST_OVER : ST_SERVE;
                end else if (ball_hit) begin
                    score_nxt = bcd_sat_inc(score);
                end
            end
            ST_OVER: begin
                // Only a paddle pulse after the counter has saturated restarts
                if (paddle && cnt == SERVE_N)
                    state_nxt = ST_IDLE;
                else if (frame_tick && cnt < SERVE_N)
                    cnt_nxt = cnt + 8'd1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register with registered level outputs decoded from the next state
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            score       <= '0;
            lives       <= LIVES_INIT;
            ball_reset  <= 1'b1;
            ball_enable <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            score       <= score_nxt;
            lives       <= lives_nxt;
            ball_reset  <= (state_nxt != ST_PLAY);
            ball_enable <= (state_nxt == ST_PLAY);
            game_over   <= (state_nxt == ST_OVER);
        end
    end

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Directed bench for pong_game_sequencer with SERVE_FRAMES=4, LIVES=3.
module tb_pong_game_sequencer;

    logic       Clock = 1'b0;
    logic       Reset, rota, rotb, vsync, ball_hit, ball_miss;
    logic       frame_tick, paddle_up, paddle_down;
    logic       ball_reset, ball_enable, game_over;
    logic [7:0] score;
    logic [3:0] lives;

    int n_checks = 0;
    int n_errors = 0;

    pong_game_sequencer #(.SERVE_FRAMES(4), .LIVES(3)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .rota        (rota),
        .rotb        (rotb),
        .vsync       (vsync),
        .ball_hit    (ball_hit),
        .ball_miss   (ball_miss),
        .frame_tick  (frame_tick),
        .paddle_up   (paddle_up),
        .paddle_down (paddle_down),
        .ball_reset  (ball_reset),
        .ball_enable (ball_enable),
        .score       (score),
        .lives       (lives),
        .game_over   (game_over)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ball_reset"},  32'(ball_reset),  32'd1);
        check({tag, "_ball_enable"}, 32'(ball_enable), 32'd0);
        check({tag, "_game_over"},   32'(game_over),   32'd0);
        check({tag, "_frame_tick"},  32'(frame_tick),  32'd0);
        check({tag, "_paddles"},     32'({paddle_up, paddle_down}), 32'd0);
        check({tag, "_score"},       32'(score),       32'h00);
        check({tag, "_lives"},       32'(lives),       32'd3);
    endtask

    // One encoder step; dir=0 expects paddle_up, dir=1 expects paddle_down
    task automatic enc_step(input logic dir, input string tag);
        int   n;
        logic up, dn;
        rotb = dir;
        tick();
        rota = 1'b1;
        n = 0; up = 1'b0; dn = 1'b0;
        while (n < 8 && !(up || dn)) begin
            tick();
            n++;
            up = paddle_up;
            dn = paddle_down;
        end
        check({tag, "_latency"}, 32'(n), 32'd3);
        check({tag, "_dir"}, 32'({up, dn}), dir ? 32'd1 : 32'd2);
        rota = 1'b0;
        repeat (4) tick();
    endtask

    task automatic frame(input string tag);
        int n;
        logic t;
        vsync = 1'b0;
        n = 0; t = 1'b0;
        while (n < 8 && !t) begin
            tick();
            n++;
            t = frame_tick;
        end
        check({tag, "_tick_latency"}, 32'(n), 32'd3);
        vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic hit();
        ball_hit = 1'b1;
        tick();
        ball_hit = 1'b0;
        tick();
    endtask

    task automatic miss();
        ball_miss = 1'b1;
        tick();
        ball_miss = 1'b0;
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; rota = 1'b0; rotb = 1'b0; vsync = 1'b1;
        ball_hit = 1'b0; ball_miss = 1'b0;
        repeat (2) tick();
        check_reset("rst");
        Reset = 1'b0;
        tick();

        // IDLE -> SERVE via paddle_down
        enc_step(1'b1, "dn");
        check("dn_lives", 32'(lives), 32'd3);
        check("dn_score", 32'(score), 32'h00);
        check("dn_ball_reset", 32'(ball_reset), 32'd1);

        // Back to IDLE, then start with paddle_up
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        enc_step(1'b0, "up");
        check("up_ball_enable", 32'(ball_enable), 32'd0);

        // Serve hold: 3 frames stay in SERVE, 4th enters PLAY
        repeat (3) frame("srv");
        check("serve3_enable", 32'(ball_enable), 32'd0);
        check("serve3_reset", 32'(ball_reset), 32'd1);
        frame("srv4");
        check("play_enable", 32'(ball_enable), 32'd1);
        check("play_reset", 32'(ball_reset), 32'd0);

        // BCD scoring and saturation
        repeat (9) hit();
        check("score_09", 32'(score), 32'h09);
        hit();
        check("score_10", 32'(score), 32'h10);
        repeat (89) hit();
        check("score_99", 32'(score), 32'h99);
        hit();
        check("score_sat", 32'(score), 32'h99);

        // Simultaneous hit and miss: miss wins
        ball_hit = 1'b1; ball_miss = 1'b1;
        tick();
        ball_hit = 1'b0; ball_miss = 1'b0;
        tick();
        check("both_lives", 32'(lives), 32'd2);
        check("both_score", 32'(score), 32'h99);
        check("both_enable", 32'(ball_enable), 32'd0);

        repeat (4) frame("srv_b");
        check("play2_enable", 32'(ball_enable), 32'd1);
        miss();
        check("miss2_lives", 32'(lives), 32'd1);
        check("miss2_over", 32'(game_over), 32'd0);
        repeat (4) frame("srv_c");
        miss();
        check("miss3_lives", 32'(lives), 32'd0);
        check("miss3_over", 32'(game_over), 32'd1);
        check("miss3_enable", 32'(ball_enable), 32'd0);
        check("miss3_reset", 32'(ball_reset), 32'd1);

        // OVER: early paddle ignored, late paddle returns to IDLE
        repeat (2) frame("ovr_a");
        enc_step(1'b0, "over_early");
        check("over_early_state", 32'(game_over), 32'd1);
        repeat (4) frame("ovr_b");
        enc_step(1'b0, "over_late");
        check("idle_over", 32'(game_over), 32'd0);
        check("idle_reset", 32'(ball_reset), 32'd1);
        check("idle_score_frozen", 32'(score), 32'h99);
        check("idle_lives_frozen", 32'(lives), 32'd0);
        enc_step(1'b1, "restart");
        check("restart_score", 32'(score), 32'h00);
        check("restart_lives", 32'(lives), 32'd3);

        // Reset during PLAY with a hit in the reset cycle
        repeat (4) frame("srv_d");
        check("play3_enable", 32'(ball_enable), 32'd1);
        repeat (2) hit();
        check("score_02", 32'(score), 32'h02);
        Reset = 1'b1; ball_hit = 1'b1;
        tick();
        Reset = 1'b0; ball_hit = 1'b0;
        check_reset("rst_mid");
        tick();
        check("post_rst_score", 32'(score), 32'h00);
        check("post_rst_enable", 32'(ball_enable), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
